// File: rtl/song_sequencer_pkg.sv
// Shared constants and types for the song sequencer.
// Field widths, tempo-modifier encodings, duration clamp and FSM states.
package song_sequencer_pkg;

    localparam int DEF_OCT_W  = 3;
    localparam int DEF_NOTE_W = 3;
    localparam int DEF_LEN_W  = 3;
    localparam int DEF_SONG_W = 2;
    localparam int DEF_IDX_W  = 6;
    localparam int DEF_CLK_W  = 32;

    // Tempo modifiers; any other encoding plays at normal speed.
    localparam logic [1:0] MOD_HALF   = 2'b10;
    localparam logic [1:0] MOD_DOUBLE = 2'b11;

    // Duration in units is 1<<len, clamped to 16 units from code 5 up.
    // Half time doubles that, so 6 bits cover the longest note (32).
    localparam int DUR_W = 6;
    localparam int LEN_CLAMP_CODE = 5;
    localparam logic [DUR_W-1:0] DUR_CLAMP = 6'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/song_sequencer_note_timer.sv
// Note duration timer: prescaler plus unit counter.
// Decodes the length code and tempo into units and pulses on the last cycle.
module note_timer
    import song_sequencer_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       mode,
    output logic             expire
);

    localparam int PRE_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [DUR_W-1:0] units_q, units_d;
    logic [DUR_W-1:0] base;
    logic [DUR_W-1:0] dur;
    logic             wrap;
    logic             last_unit;

    // Length code and tempo modifier to a duration in units.
    always_comb begin
        base = DUR_CLAMP;
        if (int'(len) < LEN_CLAMP_CODE) begin
            base = DUR_W'(1) << len;
        end
        dur = base;
        if (mode == MOD_HALF) begin
            dur = base << 1;
        end else if (mode == MOD_DOUBLE) begin
            dur = (base > DUR_W'(1)) ? (base >> 1) : DUR_W'(1);
        end
    end

    assign wrap      = (presc_q == PRE_MAX);
    assign last_unit = (units_q == dur - DUR_W'(1));
    assign expire    = run && wrap && last_unit;

    // Next prescaler and unit count; frozen whenever run is low.
    always_comb begin
        presc_d = presc_q;
        units_d = units_q;
        if (clear) begin
            presc_d = '0;
            units_d = '0;
        end else if (run) begin
            if (wrap) begin
                presc_d = '0;
                units_d = units_q + DUR_W'(1);
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            units_q <= '0;
        end else begin
            presc_q <= presc_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks one stored song and presents the current goal note.
// Owns ROM addressing, note/gap timing, tempo, pause and abort.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int OCT_W          = DEF_OCT_W,
    parameter int NOTE_W         = DEF_NOTE_W,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int SONG_W         = DEF_SONG_W,
    parameter int IDX_W          = DEF_IDX_W,
    parameter int CLK_W          = DEF_CLK_W,
    parameter int TICKS_PER_UNIT = 6250000,
    parameter int GAP_CYCLES     = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic [SONG_W-1:0] song_sel,
    input  logic [1:0]        mod,
    input  logic [CLK_W-1:0]  system_clock,
    output logic [SONG_W-1:0] rom_song,
    output logic [IDX_W-1:0]  rom_idx,
    input  logic [IDX_W-1:0]  rom_track,
    input  logic [OCT_W-1:0]  rom_octave,
    input  logic [NOTE_W-1:0] rom_note,
    input  logic [LEN_W-1:0]  rom_length,
    output logic              goal_valid,
    output logic [OCT_W-1:0]  goal_octave,
    output logic [NOTE_W-1:0] goal_note,
    output logic [LEN_W-1:0]  goal_length,
    output logic [CLK_W-1:0]  goal_clock,
    output logic [IDX_W-1:0]  note_idx,
    output logic              note_start,
    output logic              note_end,
    output logic              busy,
    output logic              done
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam logic [GAP_W-1:0] GAP_MAX =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_e        state_q, state_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [1:0]        mod_q, mod_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              goal_valid_q, goal_valid_d;
    logic [OCT_W-1:0]  goal_octave_q, goal_octave_d;
    logic [NOTE_W-1:0] goal_note_q, goal_note_d;
    logic [LEN_W-1:0]  goal_length_q, goal_length_d;
    logic [CLK_W-1:0]  goal_clock_q, goal_clock_d;
    logic              start_pend_q, start_pend_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              timer_clear;
    logic              timer_run;
    logic              expire;
    logic [IDX_W-1:0]  idx_next;

    // Timer runs only while sounding and not frozen; abort stops it dead.
    assign timer_clear = (state_q == ST_LOAD);
    assign timer_run   = (state_q == ST_PLAY) && !pause && !abort;
    assign idx_next    = idx_q + IDX_W'(1);

    note_timer #(
        .LEN_W (LEN_W),
        .TICKS (TICKS_PER_UNIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .run    (timer_run),
        .len    (goal_length_q),
        .mode   (mod_q),
        .expire (expire)
    );

    // Next-state, register updates and strobe outputs of the sequencer.
    always_comb begin
        state_d       = state_q;
        song_d        = song_q;
        mod_d         = mod_q;
        idx_d         = idx_q;
        goal_valid_d  = goal_valid_q;
        goal_octave_d = goal_octave_q;
        goal_note_d   = goal_note_q;
        goal_length_d = goal_length_q;
        goal_clock_d  = goal_clock_q;
        start_pend_d  = start_pend_q;
        gap_d         = gap_q;
        note_start    = 1'b0;
        note_end      = 1'b0;
        done          = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            goal_valid_d = 1'b0;
            start_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        song_d  = song_sel;
                        mod_d   = mod;
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (idx_q == rom_track) begin
                        state_d = ST_DONE;
                    end else begin
                        goal_octave_d = rom_octave;
                        goal_note_d   = rom_note;
                        goal_length_d = rom_length;
                        goal_clock_d  = system_clock;
                        goal_valid_d  = 1'b1;
                        start_pend_d  = 1'b1;
                        state_d       = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (!pause) begin
                        note_start   = start_pend_q;
                        start_pend_d = 1'b0;
                        if (expire) begin
                            note_end     = 1'b1;
                            idx_d        = idx_next;
                            goal_valid_d = 1'b0;
                            if (idx_next == rom_track) begin
                                state_d = ST_DONE;
                            end else if (GAP_CYCLES == 0) begin
                                state_d = ST_LOAD;
                            end else begin
                                gap_d   = '0;
                                state_d = ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (!pause) begin
                        if (gap_q == GAP_MAX) begin
                            state_d = ST_LOAD;
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            song_q        <= '0;
            mod_q         <= '0;
            idx_q         <= '0;
            goal_valid_q  <= 1'b0;
            goal_octave_q <= '0;
            goal_note_q   <= '0;
            goal_length_q <= '0;
            goal_clock_q  <= '0;
            start_pend_q  <= 1'b0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            song_q        <= song_d;
            mod_q         <= mod_d;
            idx_q         <= idx_d;
            goal_valid_q  <= goal_valid_d;
            goal_octave_q <= goal_octave_d;
            goal_note_q   <= goal_note_d;
            goal_length_q <= goal_length_d;
            goal_clock_q  <= goal_clock_d;
            start_pend_q  <= start_pend_d;
            gap_q         <= gap_d;
        end
    end

    assign rom_song    = song_q;
    assign rom_idx     = idx_q;
    assign note_idx    = idx_q;
    assign goal_valid  = goal_valid_q;
    assign goal_octave = goal_octave_q;
    assign goal_note   = goal_note_q;
    assign goal_length = goal_length_q;
    assign goal_clock  = goal_clock_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICKS_PER_UNIT=4, GAP_CYCLES=2.
// A small song ROM model is driven from rom_song/rom_idx.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        pause;
    logic [1:0]  song_sel;
    logic [1:0]  mod;
    logic [31:0] sys_clk = 32'd100;
    logic [1:0]  rom_song;
    logic [5:0]  rom_idx;
    logic [5:0]  rom_track;
    logic [2:0]  rom_octave;
    logic [2:0]  rom_note;
    logic [2:0]  rom_length;
    logic        goal_valid;
    logic [2:0]  goal_octave;
    logic [2:0]  goal_note;
    logic [2:0]  goal_length;
    logic [31:0] goal_clock;
    logic [5:0]  note_idx;
    logic        note_start;
    logic        note_end;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    int rise_c[8];
    int fall_c[8];
    int nrise, nfall, nstart, nend, ndone, done_c, bad_pulse;
    logic [2:0]  r_oct[8];
    logic [2:0]  r_note[8];
    logic [2:0]  r_len[8];
    logic [5:0]  r_idx[8];
    logic [31:0] r_gclk[8];
    logic [31:0] r_sys[8];
    logic [31:0] l_gclk[8];
    logic        busy_log[64];

    always #5 clk = ~clk;
    always @(posedge clk) sys_clk <= sys_clk + 32'd1;

    // Song 0: three notes len 0,1,2. Song 1: empty. Song 2: rest + clamp.
    always_comb begin
        rom_track  = 6'd0;
        rom_octave = 3'd0;
        rom_note   = 3'd0;
        rom_length = 3'd0;
        if (rom_song == 2'd0) begin
            rom_track = 6'd3;
            if (rom_idx < 6'd3) begin
                rom_octave = rom_idx[2:0] + 3'd2;
                rom_note   = rom_idx[2:0] + 3'd1;
                rom_length = rom_idx[2:0];
            end
        end else if (rom_song == 2'd2) begin
            rom_track = 6'd2;
            if (rom_idx == 6'd0) begin
                rom_octave = 3'd3;
                rom_note   = 3'd0;
                rom_length = 3'd1;
            end else if (rom_idx == 6'd1) begin
                rom_octave = 3'd4;
                rom_note   = 3'd5;
                rom_length = 3'd7;
            end
        end
    end

    song_sequencer #(
        .TICKS_PER_UNIT (4),
        .GAP_CYCLES     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .song_sel     (song_sel),
        .mod          (mod),
        .system_clock (sys_clk),
        .rom_song     (rom_song),
        .rom_idx      (rom_idx),
        .rom_track    (rom_track),
        .rom_octave   (rom_octave),
        .rom_note     (rom_note),
        .rom_length   (rom_length),
        .goal_valid   (goal_valid),
        .goal_octave  (goal_octave),
        .goal_note    (goal_note),
        .goal_length  (goal_length),
        .goal_clock   (goal_clock),
        .note_idx     (note_idx),
        .note_start   (note_start),
        .note_end     (note_end),
        .busy         (busy),
        .done         (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a song, then observe cycle by cycle (cycle 1 = first after start).
    task automatic run_song(input logic [1:0] s, input logic [1:0] m,
                            input int pause_at, input int pause_len,
                            input int abort_at, input int max_c);
        logic        prev_gv;
        logic        prev_end;
        logic        prev_abort;
        logic [31:0] last_gclk;
        int          tail;
        nrise = 0; nfall = 0; nstart = 0; nend = 0;
        ndone = 0; done_c = -1; bad_pulse = 0;
        foreach (busy_log[i]) busy_log[i] = 1'bx;
        prev_gv = 1'b0; prev_end = 1'b0; prev_abort = 1'b0;
        last_gclk = '0;
        tail = -1;
        song_sel = s;
        mod = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            pause = (c >= pause_at) && (c < pause_at + pause_len);
            abort = (c == abort_at);
            #1;
            if (c < 64) busy_log[c] = busy;
            if (pause && (note_start || note_end || done)) bad_pulse++;
            if (note_start !== (goal_valid && !prev_gv)) bad_pulse++;
            if (note_end && !goal_valid) bad_pulse++;
            if (goal_valid && !prev_gv) begin
                if (nrise < 8) begin
                    rise_c[nrise] = c;
                    r_oct[nrise]  = goal_octave;
                    r_note[nrise] = goal_note;
                    r_len[nrise]  = goal_length;
                    r_idx[nrise]  = note_idx;
                    r_gclk[nrise] = goal_clock;
                    r_sys[nrise]  = sys_clk;
                end
                nrise++;
            end
            if (!goal_valid && prev_gv) begin
                if (nfall < 8) begin
                    fall_c[nfall] = c;
                    l_gclk[nfall] = last_gclk;
                end
                nfall++;
                if (!prev_end && !prev_abort) bad_pulse++;
            end
            if (goal_valid) last_gclk = goal_clock;
            if (note_start) nstart++;
            if (note_end) nend++;
            if (done) begin
                ndone++;
                done_c = c;
            end
            prev_gv = goal_valid;
            prev_end = note_end;
            prev_abort = abort;
            if (ndone > 0 && tail < 0) tail = 4;
            if (tail == 0) break;
            if (tail > 0) tail--;
            tick();
        end
        pause = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        song_sel = 2'd0;
        mod = 2'd0;
        repeat (3) tick();

        chk("rst_goal_valid", goal_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_note_start", note_start, 0);
        chk("rst_note_end", note_end, 0);
        chk("rst_rom_idx", rom_idx, 0);
        chk("rst_goal_clock", goal_clock, 0);
        rst = 1'b0;
        tick();

        run_song(2'd0, 2'b00, -1, 0, -1, 200);
        chk("n_rises", nrise, 3);
        chk("n_len0", fall_c[0] - rise_c[0], 4);
        chk("n_len1", fall_c[1] - rise_c[1], 8);
        chk("n_len2", fall_c[2] - rise_c[2], 16);
        chk("n_gap0", rise_c[1] - fall_c[0], 3);
        chk("n_gap1", rise_c[2] - fall_c[1], 3);
        chk("n_first_rise", rise_c[0], 2);
        chk("n_starts", nstart, 3);
        chk("n_ends", nend, 3);
        chk("n_done_cnt", ndone, 1);
        chk("n_done_at", done_c, fall_c[2]);
        chk("n_pulses", bad_pulse, 0);
        chk("n_oct0", r_oct[0], 2);
        chk("n_note1", r_note[1], 2);
        chk("n_len_code2", r_len[2], 2);
        chk("n_idx1", r_idx[1], 1);
        chk("n_gclk0", r_gclk[0], r_sys[0] - 32'd1);
        chk("n_after_busy", busy, 0);
        repeat (2) tick();

        run_song(2'd0, 2'b10, -1, 0, -1, 200);
        chk("h_len0", fall_c[0] - rise_c[0], 8);
        chk("h_len1", fall_c[1] - rise_c[1], 16);
        chk("h_len2", fall_c[2] - rise_c[2], 32);
        chk("h_done_cnt", ndone, 1);
        repeat (2) tick();

        run_song(2'd0, 2'b11, -1, 0, -1, 200);
        chk("d_len0", fall_c[0] - rise_c[0], 4);
        chk("d_len1", fall_c[1] - rise_c[1], 4);
        chk("d_len2", fall_c[2] - rise_c[2], 8);
        chk("d_gap0", rise_c[1] - fall_c[0], 3);
        chk("d_done_cnt", ndone, 1);
        repeat (2) tick();

        run_song(2'd1, 2'b00, -1, 0, -1, 40);
        chk("e_done_at", done_c, 2);
        chk("e_done_cnt", ndone, 1);
        chk("e_rises", nrise, 0);
        repeat (2) tick();

        run_song(2'd2, 2'b00, -1, 0, -1, 200);
        chk("r_len0", fall_c[0] - rise_c[0], 8);
        chk("r_rest_note", r_note[0], 0);
        chk("r_len1_clamp", fall_c[1] - rise_c[1], 64);
        chk("r_note1", r_note[1], 5);
        chk("r_done_cnt", ndone, 1);
        repeat (2) tick();

        run_song(2'd0, 2'b00, 12, 10, -1, 200);
        chk("p_len0", fall_c[0] - rise_c[0], 4);
        chk("p_len1", fall_c[1] - rise_c[1], 18);
        chk("p_len2", fall_c[2] - rise_c[2], 16);
        chk("p_gclk_hold", l_gclk[1], r_gclk[1]);
        chk("p_pulses", bad_pulse, 0);
        chk("p_done_cnt", ndone, 1);
        repeat (2) tick();

        run_song(2'd0, 2'b00, -1, 0, 13, 40);
        chk("a_busy_before", busy_log[13], 1);
        chk("a_busy_after", busy_log[14], 0);
        chk("a_fall", fall_c[1], 14);
        chk("a_rises", nrise, 2);
        chk("a_ends", nend, 1);
        chk("a_done_cnt", ndone, 0);
        repeat (2) tick();

        run_song(2'd0, 2'b00, -1, 0, -1, 200);
        chk("rp_idx0", r_idx[0], 0);
        chk("rp_len0", fall_c[0] - rise_c[0], 4);
        chk("rp_rises", nrise, 3);
        chk("rp_done_cnt", ndone, 1);
        repeat (2) tick();

        song_sel = 2'd2;
        mod = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("x_pre_oct", goal_octave, 3);
        chk("x_pre_song", rom_song, 2);
        rst = 1'b1;
        start = 1'b1;
        tick();
        chk("x_goal_valid", goal_valid, 0);
        chk("x_goal_oct", goal_octave, 0);
        chk("x_goal_len", goal_length, 0);
        chk("x_goal_clock", goal_clock, 0);
        chk("x_rom_song", rom_song, 0);
        chk("x_note_idx", note_idx, 0);
        chk("x_busy", busy, 0);
        chk("x_strobes", {note_start, note_end, done}, 0);
        repeat (2) tick();
        chk("x_busy_held", busy, 0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("x_idle_no_start", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("x_restart_busy", busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
